core_debug_link: RTL and testbench



---
 rtl/core_debug_link_pkg.sv | 27 ++
 rtl/core_debug_link_timer.sv | 31 +++
 rtl/core_debug_link.sv | 171 +++++++++++++++++
 tb/tb_core_debug_link.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_debug_link_pkg.sv
// Shared debug-link definitions: response status codes, frame lengths,
// link FSM state encoding and the supported-command check.
package core_debug_link_pkg;

  // Response status byte values
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ERROR   = 8'h01;
  localparam logic [7:0] ST_BADCMD  = 8'h02;
  localparam logic [7:0] ST_TIMEOUT = 8'h03;

  // Frame lengths in bytes
  localparam int unsigned RX_FRAME_LEN = 6;
  localparam int unsigned TX_FRAME_LEN = 5;

  typedef enum logic [1:0] {
    S_COLLECT   = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_SEND      = 2'd3
  } link_state_t;

  // Commands the debug unit understands (run, halt, stop)
  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == 4'h0) || (cmd == 4'h8) || (cmd == 4'hF);
  endfunction

endpackage

// File: rtl/core_debug_link_timer.sv
// Response timeout counter for the debug link.
// Ports:
//   iCLOCK, inRESET : clock, asynchronous active-low reset
//   clear           : forces the count back to 0
//   enable          : count one per cycle while high
//   expired         : high while enabled and the count equals P_TIMEOUT_CYCLES-1
module core_debug_link_timer #(
  parameter logic [15:0] P_TIMEOUT_CYCLES = 16'd1024
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_q;

  assign expired = enable && (count_q == (P_TIMEOUT_CYCLES - 16'd1));

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/core_debug_link.sv
// Host byte-stream to core debug unit bridge.
// Collects a 6-byte command frame ({sync,cmd}, target, data MSB first),
// issues supported commands to the debug unit, waits for its response and
// returns a 5-byte reply (status, data MSB first).
// Ports:
//   iCLOCK, inRESET                      : clock, asynchronous active-low reset
//   iRX_VALID/iRX_DATA/oRX_READY         : host byte input (valid/ready)
//   oTX_VALID/oTX_DATA/iTX_READY         : response byte output (valid/ready)
//   oCMD_REQ/COMMAND/TARGET/DATA, iCMD_BUSY : command to the debug unit
//   iRESP_VALID/iRESP_ERROR/iRESP_DATA   : debug unit response
// Build option: define CORE_DEBUG_LINK_TIMEOUT_EN to abandon a response wait
// after P_TIMEOUT_CYCLES cycles (status 8'h03); otherwise the wait is unbounded.
module core_debug_link
  import core_debug_link_pkg::*;
#(
  parameter logic [15:0] P_TIMEOUT_CYCLES = 16'd1024,
  parameter logic [3:0]  P_SYNC_NIBBLE    = 4'hA
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRX_VALID,
  input  logic [7:0]  iRX_DATA,
  output logic        oRX_READY,
  output logic        oTX_VALID,
  output logic [7:0]  oTX_DATA,
  input  logic        iTX_READY,
  output logic        oCMD_REQ,
  output logic [3:0]  oCMD_COMMAND,
  output logic [7:0]  oCMD_TARGET,
  output logic [31:0] oCMD_DATA,
  input  logic        iCMD_BUSY,
  input  logic        iRESP_VALID,
  input  logic        iRESP_ERROR,
  input  logic [31:0] iRESP_DATA
);

  localparam logic [2:0] RX_LAST = 3'(RX_FRAME_LEN - 1);
  localparam logic [2:0] TX_LAST = 3'(TX_FRAME_LEN - 1);

  link_state_t state_q, state_d;
  logic [2:0]  rx_cnt_q, tx_cnt_q;
  logic [3:0]  cmd_q;
  logic [7:0]  target_q;
  logic [31:0] data_q;
  logic [7:0]  status_q;
  logic [31:0] resp_q;
  logic [7:0]  tx_byte;

  logic rx_fire, tx_fire, sync_ok, rx_last, tx_last, timed_out;

  assign rx_fire = iRX_VALID && (state_q == S_COLLECT);
  assign tx_fire = iTX_READY && (state_q == S_SEND);
  assign sync_ok = (iRX_DATA[7:4] == P_SYNC_NIBBLE);
  assign rx_last = rx_fire && (rx_cnt_q == RX_LAST);
  assign tx_last = tx_fire && (tx_cnt_q == TX_LAST);

`ifdef CORE_DEBUG_LINK_TIMEOUT_EN
  core_debug_link_timer #(
    .P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES)
  ) u_timer (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .clear  (state_q != S_WAIT_RESP),
    .enable (state_q == S_WAIT_RESP),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: begin
        // cmd_q already holds the command captured from byte 0
        if (rx_last) begin
          state_d = cmd_supported(cmd_q) ? S_ISSUE : S_SEND;
        end
      end
      S_ISSUE: begin
        if (!iCMD_BUSY) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (iRESP_VALID || timed_out) state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_last) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      cmd_q    <= '0;
      target_q <= '0;
      data_q   <= '0;
      status_q <= '0;
      resp_q   <= '0;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          if (rx_fire) begin
            if (rx_cnt_q == 3'd0) begin
              // Header with a wrong sync nibble is dropped; keep hunting
              if (sync_ok) begin
                cmd_q    <= iRX_DATA[3:0];
                rx_cnt_q <= 3'd1;
              end
            end else if (rx_cnt_q == 3'd1) begin
              target_q <= iRX_DATA;
              rx_cnt_q <= 3'd2;
            end else begin
              data_q   <= {data_q[23:0], iRX_DATA};
              rx_cnt_q <= rx_last ? 3'd0 : rx_cnt_q + 3'd1;
            end
            if (rx_last && !cmd_supported(cmd_q)) begin
              status_q <= ST_BADCMD;
              resp_q   <= '0;
            end
          end
        end
        S_WAIT_RESP: begin
          // A response in the limit cycle takes priority over the timeout
          if (iRESP_VALID) begin
            status_q <= iRESP_ERROR ? ST_ERROR : ST_OK;
            resp_q   <= iRESP_DATA;
          end else if (timed_out) begin
            status_q <= ST_TIMEOUT;
            resp_q   <= '0;
          end
        end
        S_SEND: begin
          if (tx_fire) tx_cnt_q <= tx_last ? 3'd0 : tx_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_byte = '0;
    case (tx_cnt_q)
      3'd0:    tx_byte = status_q;
      3'd1:    tx_byte = resp_q[31:24];
      3'd2:    tx_byte = resp_q[23:16];
      3'd3:    tx_byte = resp_q[15:8];
      3'd4:    tx_byte = resp_q[7:0];
      default: tx_byte = '0;
    endcase
  end

  assign oRX_READY    = (state_q == S_COLLECT);
  assign oCMD_REQ     = (state_q == S_ISSUE);
  assign oCMD_COMMAND = cmd_q;
  assign oCMD_TARGET  = target_q;
  assign oCMD_DATA    = data_q;
  assign oTX_VALID    = (state_q == S_SEND);
  assign oTX_DATA     = (state_q == S_SEND) ? tx_byte : 8'h00;

endmodule

// File: tb/tb_core_debug_link.sv
// Self-checking bench for core_debug_link: expected commands and response
// bytes are queued by the stimulus; a negedge monitor pops and compares on
// every command acceptance and every TX transfer.
module tb_core_debug_link;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRX_VALID;
  logic [7:0]  iRX_DATA;
  logic        oRX_READY;
  logic        oTX_VALID;
  logic [7:0]  oTX_DATA;
  logic        iTX_READY;
  logic        oCMD_REQ;
  logic [3:0]  oCMD_COMMAND;
  logic [7:0]  oCMD_TARGET;
  logic [31:0] oCMD_DATA;
  logic        iCMD_BUSY;
  logic        iRESP_VALID;
  logic        iRESP_ERROR;
  logic [31:0] iRESP_DATA;

  int checks   = 0;
  int failures = 0;

  logic [43:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];
  logic [43:0] e_cmd;
  logic [7:0]  e_tx;

  core_debug_link #(
    .P_TIMEOUT_CYCLES(16'd16),
    .P_SYNC_NIBBLE   (4'hA)
  ) dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRX_VALID   (iRX_VALID),
    .iRX_DATA    (iRX_DATA),
    .oRX_READY   (oRX_READY),
    .oTX_VALID   (oTX_VALID),
    .oTX_DATA    (oTX_DATA),
    .iTX_READY   (iTX_READY),
    .oCMD_REQ    (oCMD_REQ),
    .oCMD_COMMAND(oCMD_COMMAND),
    .oCMD_TARGET (oCMD_TARGET),
    .oCMD_DATA   (oCMD_DATA),
    .iCMD_BUSY   (iCMD_BUSY),
    .iRESP_VALID (iRESP_VALID),
    .iRESP_ERROR (iRESP_ERROR),
    .iRESP_DATA  (iRESP_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  // Monitor: compare every accepted command and every transferred byte
  always @(negedge iCLOCK) begin
    if (inRESET) begin
      if (oCMD_REQ && !iCMD_BUSY) begin
        checks++;
        if (exp_cmd.size() == 0) begin
          failures++;
          $display("FAIL cmd_unexpected: got %h expected no command", {oCMD_COMMAND, oCMD_TARGET, oCMD_DATA});
        end else begin
          e_cmd = exp_cmd.pop_front();
          if ({oCMD_COMMAND, oCMD_TARGET, oCMD_DATA} !== e_cmd) begin
            failures++;
            $display("FAIL cmd: got %h expected %h", {oCMD_COMMAND, oCMD_TARGET, oCMD_DATA}, e_cmd);
          end
        end
      end
      if (oTX_VALID && iTX_READY) begin
        checks++;
        if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected: got %h expected no byte", oTX_DATA);
        end else begin
          e_tx = exp_tx.pop_front();
          if (oTX_DATA !== e_tx) begin
            failures++;
            $display("FAIL tx_byte: got %h expected %h", oTX_DATA, e_tx);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    iRX_VALID = 1'b1;
    iRX_DATA  = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge iCLOCK);
      if (oRX_READY) begin
        @(posedge iCLOCK);
        #1;
        iRX_VALID = 1'b0;
        return;
      end
    end
    iRX_VALID = 1'b0;
    checks++;
    failures++;
    $display("FAIL rx_handshake_timeout: got no ready expected ready within 200 cycles");
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) send_byte(f[47 - 8*i -: 8]);
  endtask

  task automatic respond(input logic [31:0] d, input logic err);
    iRESP_VALID = 1'b1;
    iRESP_DATA  = d;
    iRESP_ERROR = err;
    @(posedge iCLOCK);
    #1;
    iRESP_VALID = 1'b0;
    iRESP_DATA  = '0;
    iRESP_ERROR = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_tx.size() == 0) break;
      @(negedge iCLOCK);
    end
    @(posedge iCLOCK);
    #1;
    checks++;
    if (exp_tx.size() != 0 || exp_cmd.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d tx/%0d cmd pending expected 0/0", exp_tx.size(), exp_cmd.size());
    end
  endtask

  task automatic push_tx(input logic [7:0] s, input logic [31:0] d);
    exp_tx.push_back(s);
    exp_tx.push_back(d[31:24]);
    exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, oRX_READY, 1'b1);
    check({tag, "_tx_valid"}, oTX_VALID, 1'b0);
    check({tag, "_tx_data"}, oTX_DATA, 8'h00);
    check({tag, "_cmd_req"}, oCMD_REQ, 1'b0);
    check({tag, "_cmd_command"}, oCMD_COMMAND, 4'h0);
    check({tag, "_cmd_target"}, oCMD_TARGET, 8'h00);
    check({tag, "_cmd_data"}, oCMD_DATA, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    inRESET     = 1'b0;
    iRX_VALID   = 1'b0;
    iRX_DATA    = '0;
    iTX_READY   = 1'b1;
    iCMD_BUSY   = 1'b0;
    iRESP_VALID = 1'b0;
    iRESP_ERROR = 1'b0;
    iRESP_DATA  = '0;
    repeat (3) @(posedge iCLOCK);
    @(negedge iCLOCK);
    check_reset_values("reset");
    @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;

    // Basic command with successful response
    exp_cmd.push_back({4'h0, 8'h40, 32'h0});
    push_tx(8'h00, 32'h12345678);
    send_frame(48'hA0_40_00_00_00_00);
    check("cmd_req_latency", oCMD_REQ, 1'b1);
    check("rx_ready_in_issue", oRX_READY, 1'b0);
    @(posedge iCLOCK);
    #1;
    respond(32'h12345678, 1'b0);
    wait_drain();

    // Busy debug unit holds the request, then error response with TX stall
    iCMD_BUSY = 1'b1;
    exp_cmd.push_back({4'hF, 8'h00, 32'h0});
    push_tx(8'h01, 32'hCAFEF00D);
    send_frame(48'hAF_00_00_00_00_00);
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLOCK);
      check("cmd_req_while_busy", oCMD_REQ, 1'b1);
      @(posedge iCLOCK);
      #1;
    end
    iCMD_BUSY = 1'b0;
    @(negedge iCLOCK);
    check("cmd_req_accept_cycle", oCMD_REQ, 1'b1);
    @(posedge iCLOCK);
    #1;
    check("cmd_req_after_accept", oCMD_REQ, 1'b0);
    iTX_READY = 1'b0;
    respond(32'hCAFEF00D, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLOCK);
      check("stall_tx_valid", oTX_VALID, 1'b1);
      check("stall_tx_data", oTX_DATA, 8'h01);
    end
    @(posedge iCLOCK);
    #1;
    iTX_READY = 1'b1;
    wait_drain();

    // Stray response in COLLECT ignored; bad sync byte discarded
    respond(32'hDEADDEAD, 1'b1);
    check("stray_resp_no_tx", oTX_VALID, 1'b0);
    exp_cmd.push_back({4'hF, 8'h00, 32'h0});
    push_tx(8'h00, 32'h00000001);
    send_byte(8'h55);
    check("resync_rx_ready", oRX_READY, 1'b1);
    send_frame(48'hAF_00_00_00_00_00);
    check("resync_cmd_req", oCMD_REQ, 1'b1);
    @(posedge iCLOCK);
    #1;
    respond(32'h00000001, 1'b0);
    wait_drain();

    // Unsupported command: no issue, status 02
    push_tx(8'h02, 32'h0);
    send_frame(48'hA1_03_DE_AD_BE_EF);
    check("badcmd_no_req", oCMD_REQ, 1'b0);
    check("badcmd_tx_valid", oTX_VALID, 1'b1);
    wait_drain();

    // Reset after the third TX byte abandons the reply
    iTX_READY = 1'b0;
    exp_cmd.push_back({4'h8, 8'h11, 32'h01020304});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'hA5);
    send_frame(48'hA8_11_01_02_03_04);
    @(posedge iCLOCK);
    #1;
    respond(32'hA5A5A5A5, 1'b0);
    iTX_READY = 1'b1;
    repeat (3) @(posedge iCLOCK);
    #1;
    iTX_READY = 1'b0;
    inRESET = 1'b0;
    #2;
    check_reset_values("midsend_reset");
    @(posedge iCLOCK);
    #1;
    inRESET   = 1'b1;
    iTX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLOCK);
      check("no_resume_after_reset", oTX_VALID, 1'b0);
    end
    @(posedge iCLOCK);
    #1;
    exp_cmd.push_back({4'h0, 8'h22, 32'h11223344});
    push_tx(8'h00, 32'h0BADF00D);
    send_frame(48'hA0_22_11_22_33_44);
    @(posedge iCLOCK);
    #1;
    respond(32'h0BADF00D, 1'b0);
    wait_drain();

`ifdef CORE_DEBUG_LINK_TIMEOUT_EN
    // No response: timeout after 16 cycles in WAIT_RESP
    begin
      int n;
      exp_cmd.push_back({4'h8, 8'h00, 32'h0});
      push_tx(8'h03, 32'h0);
      send_frame(48'hA8_00_00_00_00_00);
      @(posedge iCLOCK);
      #1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge iCLOCK);
        if (oTX_VALID) break;
        n++;
      end
      check("timeout_wait_cycles", n, 16);
      wait_drain();
    end
    // Response in the limit cycle wins over the timeout
    exp_cmd.push_back({4'h8, 8'h00, 32'h0});
    push_tx(8'h00, 32'h13579BDF);
    send_frame(48'hA8_00_00_00_00_00);
    @(posedge iCLOCK);
    #1;
    repeat (15) @(posedge iCLOCK);
    #1;
    respond(32'h13579BDF, 1'b0);
    wait_drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
